// File: rtl/mult_appx_pkg.sv
// Shared types and helpers for the pipelined approximate multiplier.
package mult_appx_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOG1  = 2'd1,
    MODE_LOG2  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Index of the highest set bit among the low `width` bits; 0 when none is set.
  function automatic int unsigned lod_idx(input logic [63:0] value, input int unsigned width);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i < width) && value[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mult_appx_pipe_if.sv
// Operand/result handshake bundle for mult_appx_pipe.
interface mult_appx_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_y;
  logic [1:0]         out_mode;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_y, out_mode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_y, out_mode
  );
endinterface

// File: rtl/mult_appx_lod.sv
// Combinational leading-one detector: index of the top set bit plus a nonzero flag.
module mult_appx_lod
  import mult_appx_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [SHW-1:0]   idx_o,
  output logic             nz_o
);

  assign idx_o = SHW'(lod_idx(64'(val_i), WIDTH));
  assign nz_o  = |val_i;

endmodule

// File: rtl/mult_appx_pipe.sv
// Two-stage approximate unsigned multiplier: exact, nearest-power-of-two and
// two-leading-term truncation modes behind a valid/ready handshake.
module mult_appx_pipe
  import mult_appx_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHW = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  mult_appx_pipe_if.slave  bus_io
);

  localparam int unsigned PW = 2 * WIDTH;

  logic en;
  logic accept;

  // Stage 1 decode
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_rem;
  logic [WIDTH-1:0] one_w;
  logic [SHW-1:0]   k;
  logic [SHW-1:0]   j;
  logic [SHW-1:0]   s1;
  logic             b_nz;
  logic             rem_nz;
  logic             round_up;
  mode_e            mode_in;

  // Stage 1 registers
  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SHW-1:0]   k_q;
  logic [SHW-1:0]   j_q;
  logic [SHW-1:0]   s1_q;
  logic             t2_q;
  logic             z_q;
  mode_e            mode_q;

  // Stage 2 (output) registers
  logic             out_valid_d, out_valid_q;
  logic [PW-1:0]    y_d, out_y_q;
  mode_e            out_mode_q;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;

  assign en              = !out_valid_q || bus_io.out_ready;
  assign accept          = en && bus_io.in_valid;
  assign bus_io.in_ready = en;
  assign b               = bus_io.in_b;
  assign one_w           = WIDTH'(1);

  mult_appx_lod #(.WIDTH(WIDTH)) u_lod_k (
    .val_i (b),
    .idx_o (k),
    .nz_o  (b_nz)
  );

  mult_appx_lod #(.WIDTH(WIDTH)) u_lod_j (
    .val_i (b_rem),
    .idx_o (j),
    .nz_o  (rem_nz)
  );

  always_comb begin
    b_rem    = b & ~(one_w << k);
    // Bit k of (b << 1) is b[k-1]; zero when k == 0, so no rounding below bit 0.
    round_up = |((b << 1) & (one_w << k));
    s1       = round_up ? k + SHW'(1) : k;
    mode_in  = (bus_io.in_mode == MODE_RSVD) ? MODE_EXACT : mode_e'(bus_io.in_mode);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (en) begin
      s1_valid_d  = bus_io.in_valid;
      out_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      j_q        <= '0;
      s1_q       <= '0;
      t2_q       <= 1'b0;
      z_q        <= 1'b0;
      mode_q     <= MODE_EXACT;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        a_q    <= bus_io.in_a;
        b_q    <= b;
        k_q    <= k;
        j_q    <= j;
        s1_q   <= s1;
        t2_q   <= rem_nz;
        z_q    <= !b_nz;
        mode_q <= mode_in;
      end
    end
  end

  always_comb begin
    a_ext = {{WIDTH{1'b0}}, a_q};
    b_ext = {{WIDTH{1'b0}}, b_q};
    y_d   = '0;
    if (!z_q) begin
      case (mode_q)
        MODE_LOG1: y_d = a_ext << s1_q;
        MODE_LOG2: y_d = (a_ext << k_q) + (t2_q ? (a_ext << j_q) : '0);
        default:   y_d = a_ext * b_ext;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_mode_q  <= MODE_EXACT;
    end else begin
      out_valid_q <= out_valid_d;
      if (en && s1_valid_q) begin
        out_y_q    <= y_d;
        out_mode_q <= mode_q;
      end
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_y     = out_y_q;
  assign bus_io.out_mode  = out_mode_q;

endmodule

// File: doc/mult_appx_pipe.md
Name: mult_appx_pipe

Overview:
Parametrised, pipelined approximate unsigned multiplier. It is the successor to the team's 16-bit power-of-two-rounding multiplier. Adds configurable width, three per-transaction modes (exact, one-term log rounding, two-term truncation), a 2-stage pipeline and a valid/ready handshake. Used as a drop-in functional unit in the energy/error exploration datapaths.

Parameters:
WIDTH, 16, operand width in bits (>=4); product is 2*WIDTH bits.
SHW, $clog2(WIDTH+1), width of a shift amount (derived; not to be overridden).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/mode valid
in_ready  output  1  block can accept an input this cycle
in_a  input  WIDTH  multiplicand, unsigned
in_b  input  WIDTH  multiplier, unsigned (the approximated operand)
in_mode  input  2  0=exact, 1=one-term rounded, 2=two-term truncated, 3=reserved (treated as 0)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_y  output  2*WIDTH  product
out_mode  output  2  mode the result was computed with (3 reported as 0)

Behaviour:
- Reset (async assert, sync release): both stage valid bits=0, out_valid=0, out_y=0, out_mode=0. in_ready is combinational and reads 1 after reset.
- Handshake: transfer on valid&ready at each side. The pipeline advances when en = !out_valid | out_ready. in_ready = en.
- No combinational path from in_valid to out_valid. out_y and out_mode hold stable while out_valid & !out_ready.
- Latency: exactly 2 cycles from input accept to out_valid, with no bubbles. Throughput is 1 per cycle while out_ready=1.
- Stage 1 (registered on en):
  - Captures a, mode.
  - k = index of the leading one of b.
  - For mode 1: s1 = k+1 if k>=1 and b[k-1]=1, else k. This rounds to the nearest power of two; the tie 1.5*2^k rounds up.
  - For mode 2: j = index of the leading one of b with bit k cleared; flag t2 = (that value != 0).
  - zero flag z = (b==0).
  - For mode 0, b is carried through unchanged.
- Stage 2 (registered on en):
  - mode 0: y = a*b, full 2*WIDTH bits.
  - mode 1: y = z ? 0 : a<<s1. The maximum shift is WIDTH, which always fits 2*WIDTH bits.
  - mode 2: y = z ? 0 : (a<<k) + (t2 ? a<<j : 0). Never exceeds the exact product.
- Stage-1 valid clears when en=1 and no input is accepted. Stage-2 (out) valid loads stage-1 valid when en=1.
- Boundaries:
  - b=0 gives 0 in all modes.
  - b=1 gives a.
  - b=2 gives a<<1 in modes 1 and 2.
  - b=3: mode 1 gives a<<2; mode 2 gives 3a (exact).
  - b = all-ones: mode 1 gives a<<WIDTH.
  - a=0 gives 0.
- Simultaneous out_ready and in_valid with a full pipeline: accept and retire in the same cycle, no loss.
- Reset mid-operation discards all in-flight results. No spurious out_valid after release.

Decomposition:
- Package mult_appx_pkg: mode constants (MODE_EXACT=0, MODE_LOG1=1, MODE_LOG2=2), the mode typedef, and a function lod_idx(value, WIDTH) for leading-one index.
- One sub-module: mult_appx_lod. It is a combinational leading-one detector returning index and a nonzero flag. It is instantiated twice in stage 1, once for k and once for j.

Test Plan:
- WIDTH=16, mode 1, out_ready=1, back-to-back inputs:
  - a=1000, b=3 -> 4000
  - a=1000, b=2 -> 2000
  - b=0 -> 0
  - a=0xFFFF, b=49152 -> 0xFFFF0000
  - a=0xFFFF, b=49151 -> 0x7FFF8000
  - Results arrive exactly 2 cycles after each input, in order.
- Mode 2: a=100, b=11 -> 1000. Mode 0: a=0xFFFF, b=0xFFFF -> 0xFFFE0001. Mode 3: a=7, b=9 -> 63, with out_mode=0.
- Backpressure: stream 6 inputs and hold out_ready=0 for 4 cycles.
  - in_ready drops once both stages are full.
  - out_y stays stable while stalled.
  - All 6 results emerge in order, none duplicated or lost.
- Full pipeline with in_valid=out_ready=1 every cycle for 20 cycles -> 20 results, one per cycle.
- Assert rst_n low while 2 transactions are in flight -> out_valid=0 immediately; no output after release until a new input plus 2 cycles.
- Random compare vs reference model, WIDTH=8 and WIDTH=16, all modes, 10k vectors:
  - mode 1 relative error within ±33%
  - mode 2 relative error within -25%
  - mode 0 exact
